// File: rtl/cross_bar_arbiter_if.sv
// Request/address/acknowledge bundle between bus masters, slaves and the crossbar arbiter.
// The arbiter sits on the slave modport; whoever drives the requests uses the master modport.
interface cross_bar_arbiter_if #(
    parameter int MASTER_N = 4,
    parameter int SLAVE_N  = 4,
    parameter int MASTER_W = 2,
    parameter int SLAVE_W  = 2,
    parameter int ADDR_W   = 8
);
    logic [MASTER_N:1]              master_req;
    logic [MASTER_N:1][ADDR_W-1:0]  master_addr;
    logic [SLAVE_N:1]               slave_ack;
    logic [SLAVE_N:1][MASTER_W:0]   slave_mux;
    logic [MASTER_N:1][SLAVE_W:0]   master_mux;

    modport master (
        output master_req,
        output master_addr,
        output slave_ack,
        input  slave_mux,
        input  master_mux
    );

    modport slave (
        input  master_req,
        input  master_addr,
        input  slave_ack,
        output slave_mux,
        output master_mux
    );
endinterface

// File: rtl/cross_bar_arbiter.sv
// Crossbar arbiter: one round-robin IDLE/BUSY FSM per slave picks which master drives it,
// and master_mux is the inverse map decoded from the registered slave selects.
package cross_bar_pkg;
    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;
    localparam int MASTER_W = 2;
    localparam int SLAVE_W  = 2;
    localparam int ADDR_W   = 8;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

module cross_bar_arbiter #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int SLAVE_N  = cross_bar_pkg::SLAVE_N,
    parameter int MASTER_W = cross_bar_pkg::MASTER_W,
    parameter int SLAVE_W  = cross_bar_pkg::SLAVE_W
) (
    input  logic               clk,
    input  logic               aresetn,
    cross_bar_arbiter_if.slave bus
);
    localparam int ADDR_W = cross_bar_pkg::ADDR_W;
    localparam logic [MASTER_W:0] LAST_RST = (MASTER_W+1)'(MASTER_N);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [SLAVE_W:0]  target [MASTER_N:1];
    logic [MASTER_W:0] grant_q [SLAVE_N:1];

    genvar gi;

    // Top address bits pick a 0-based slave; slaves are numbered from 1.
    generate
        for (gi = 1; gi <= MASTER_N; gi++) begin : g_dec
            assign target[gi] = {1'b0, bus.master_addr[gi][ADDR_W-1 -: SLAVE_W]} + (SLAVE_W+1)'(1);
        end
    endgenerate

    generate
        for (gi = 1; gi <= SLAVE_N; gi++) begin : g_slave
            state_t            state_q, state_d;
            logic [MASTER_W:0] grant_d;
            logic [MASTER_W:0] last_q, last_d;
            logic [MASTER_N:1] cand;
            logic              found;
            logic [MASTER_W:0] winner;
            logic [MASTER_W:0] probe;

            always_comb begin
                cand = '0;
                for (int m = 1; m <= MASTER_N; m++) begin
                    cand[m] = bus.master_req[m] && (target[m] == (SLAVE_W+1)'(gi));
                end
            end

            // Scan starting just after the last completed grant, wrapping MASTER_N -> 1.
            always_comb begin
                found  = 1'b0;
                winner = '0;
                probe  = '0;
                for (int k = 1; k <= MASTER_N; k++) begin
                    probe = (MASTER_W+1)'(((int'(last_q) - 1 + k) % MASTER_N) + 1);
                    if (!found && cand[probe]) begin
                        found  = 1'b1;
                        winner = probe;
                    end
                end
            end

            always_comb begin
                state_d = state_q;
                grant_d = grant_q[gi];
                last_d  = last_q;
                case (state_q)
                    IDLE: begin
                        if (found) begin
                            state_d = BUSY;
                            grant_d = winner;
                        end
                    end
                    BUSY: begin
                        // A dropped request wins over a simultaneous ack: abort, history kept.
                        if (!bus.master_req[grant_q[gi]]) begin
                            state_d = IDLE;
                            grant_d = '0;
                        end else if (bus.slave_ack[gi]) begin
                            state_d = IDLE;
                            grant_d = '0;
                            last_d  = grant_q[gi];
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (!aresetn) begin
                    state_q     <= IDLE;
                    grant_q[gi] <= '0;
                    last_q      <= LAST_RST;
                end else begin
                    state_q     <= state_d;
                    grant_q[gi] <= grant_d;
                    last_q      <= last_d;
                end
            end
        end
    endgenerate

    always_comb begin
        bus.slave_mux = '0;
        for (int s = 1; s <= SLAVE_N; s++) begin
            bus.slave_mux[s] = grant_q[s];
        end
    end

    always_comb begin
        bus.master_mux = '0;
        for (int m = 1; m <= MASTER_N; m++) begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                if (grant_q[s] == (MASTER_W+1)'(m)) begin
                    bus.master_mux[m] = (SLAVE_W+1)'(s);
                end
            end
        end
    end

    // A master must never be connected to two slaves at once.
    logic dup_grant;
    always_comb begin
        dup_grant = 1'b0;
        for (int a = 1; a <= SLAVE_N; a++) begin
            for (int b = a + 1; b <= SLAVE_N; b++) begin
                if (grant_q[a] != '0 && grant_q[a] == grant_q[b]) begin
                    dup_grant = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aresetn) begin
            assert (!dup_grant);
        end
    end
endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Directed bench for cross_bar_arbiter: a table of per-cycle stimulus with expected selects,
// followed by a reset-during-transfer sequence.
module tb_cross_bar_arbiter;
    logic clk = 1'b0;
    logic aresetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cross_bar_arbiter_if #(
        .MASTER_N(4), .SLAVE_N(4), .MASTER_W(2), .SLAVE_W(2), .ADDR_W(8)
    ) bus ();

    cross_bar_arbiter dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    typedef struct {
        logic [4:1]       req;
        logic [4:1][1:0]  top;
        logic [4:1]       ack;
        logic [4:1][2:0]  sm;
        logic [4:1][2:0]  mm;
    } vec_t;

    // Nibble-per-index hex encoding: 16'h4321 means index4=4, index3=3, index2=2, index1=1.
    function automatic vec_t mk(input logic [3:0] req, input logic [15:0] top,
                                input logic [3:0] ack, input logic [15:0] sm,
                                input logic [15:0] mm);
        vec_t r;
        r.req = req;
        r.ack = ack;
        for (int i = 1; i <= 4; i++) begin
            r.top[i] = top[4*(i-1) +: 2];
            r.sm[i]  = sm[4*(i-1) +: 3];
            r.mm[i]  = mm[4*(i-1) +: 3];
        end
        return r;
    endfunction

    task automatic drive(input logic [4:1] req, input logic [4:1][1:0] top, input logic [4:1] ack);
        bus.master_req = req;
        for (int m = 1; m <= 4; m++) begin
            bus.master_addr[m] = {top[m], 6'h15};
        end
        bus.slave_ack = ack;
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vec [23];

    initial begin
        // Reset state: everything starts in IDLE with last_grant = 4.
        vec[0]  = mk(4'b0010, 16'h0010, 4'b0000, 16'h0020, 16'h0020); // m2 -> s2
        vec[1]  = mk(4'b0000, 16'h0010, 4'b0000, 16'h0000, 16'h0000); // m2 aborts
        vec[2]  = mk(4'b1101, 16'h2222, 4'b0000, 16'h0100, 16'h0003); // m1,m3,m4 -> s3: m1
        vec[3]  = mk(4'b1101, 16'h2222, 4'b0100, 16'h0000, 16'h0000);
        vec[4]  = mk(4'b1101, 16'h2222, 4'b0000, 16'h0300, 16'h0300); // m3
        vec[5]  = mk(4'b1101, 16'h2222, 4'b0100, 16'h0000, 16'h0000);
        vec[6]  = mk(4'b1101, 16'h2222, 4'b0000, 16'h0400, 16'h3000); // m4
        vec[7]  = mk(4'b1101, 16'h2222, 4'b0100, 16'h0000, 16'h0000);
        vec[8]  = mk(4'b1101, 16'h2222, 4'b0000, 16'h0100, 16'h0003); // m1 again
        vec[9]  = mk(4'b1101, 16'h2222, 4'b0100, 16'h0000, 16'h0000);
        vec[10] = mk(4'b1101, 16'h2222, 4'b0000, 16'h0300, 16'h0300); // m3
        vec[11] = mk(4'b1101, 16'h2222, 4'b0100, 16'h0000, 16'h0000);
        vec[12] = mk(4'b1111, 16'h3210, 4'b0000, 16'h4321, 16'h4321); // parallel grants
        vec[13] = mk(4'b1111, 16'h3200, 4'b0000, 16'h4321, 16'h4321); // m2 addr moves: held
        vec[14] = mk(4'b1110, 16'h3200, 4'b0011, 16'h4300, 16'h4300); // s1 abort+ack, s2 ack
        vec[15] = mk(4'b1111, 16'h3200, 4'b0000, 16'h4301, 16'h4301); // s1 last still 4 -> m1
        vec[16] = mk(4'b0000, 16'h3200, 4'b0000, 16'h0000, 16'h0000);
        vec[17] = mk(4'b0000, 16'h3200, 4'b1111, 16'h0000, 16'h0000); // ack while idle ignored
        vec[18] = mk(4'b0001, 16'h0000, 4'b0000, 16'h0001, 16'h0001);
        vec[19] = mk(4'b0010, 16'h0000, 4'b0000, 16'h0000, 16'h0000); // m1 drops before ack
        vec[20] = mk(4'b0010, 16'h0000, 4'b0000, 16'h0002, 16'h0010);
        vec[21] = mk(4'b0010, 16'h0000, 4'b0001, 16'h0000, 16'h0000); // s1 last = 2
        vec[22] = mk(4'b0100, 16'h0000, 4'b0000, 16'h0003, 16'h0100); // s1 -> m3

        aresetn = 1'b0;
        drive(4'b0000, '0, 4'b0000);
        step();
        step();
        chk("reset_slave_mux", bus.slave_mux, 12'h000);
        chk("reset_master_mux", bus.master_mux, 12'h000);
        $display("reset sm=%h mm=%h", bus.slave_mux, bus.master_mux);
        aresetn = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(vec[i].req, vec[i].top, vec[i].ack);
            step();
            chk($sformatf("vec%0d_slave_mux", i), bus.slave_mux, vec[i].sm);
            chk($sformatf("vec%0d_master_mux", i), bus.master_mux, vec[i].mm);
            $display("vec %0d req=%b ack=%b sm=%h mm=%h", i, vec[i].req, vec[i].ack,
                     bus.slave_mux, bus.master_mux);
        end

        // Reset while s1 is granted to m3 with ack high: grant dropped, history back to 4.
        aresetn = 1'b0;
        drive(4'b0100, '0, 4'b0001);
        step();
        chk("rst_busy_slave_mux", bus.slave_mux, 12'h000);
        chk("rst_busy_master_mux", bus.master_mux, 12'h000);
        $display("reset-in-busy sm=%h mm=%h", bus.slave_mux, bus.master_mux);
        aresetn = 1'b1;
        drive(4'b0110, '0, 4'b0000);
        step();
        chk("post_rst_slave_mux", bus.slave_mux, {3'd0, 3'd0, 3'd0, 3'd2});
        chk("post_rst_master_mux", bus.master_mux, {3'd0, 3'd0, 3'd1, 3'd0});
        $display("post-reset grant sm=%h mm=%h", bus.slave_mux, bus.master_mux);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
